// File: rtl/boid_plotter_if.sv
// Handshake bundles around boid_plotter: the boid position feed and the frame-buffer write port.
interface boid_pos_if #(parameter int COLOR_W = 8);
  logic               pos_valid;
  logic               pos_ready;
  logic [31:0]        x, y, px, py;
  logic [COLOR_W-1:0] boid_color;
  modport master (output pos_valid, x, y, px, py, boid_color, input pos_ready);
  modport slave  (input pos_valid, x, y, px, py, boid_color, output pos_ready);
endinterface

interface fb_wr_if #(parameter int ADDR_W = 19, parameter int COLOR_W = 8);
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic               wr_ready;
  modport master (output wr_en, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_en, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/boid_plotter.sv
// Turns one boid update into an erase write (old pixel) and a draw write (new pixel).
// Optional BOID_SPRITE_2X2_EN: each phase writes a 2x2 sprite instead of a single pixel.
module boid_plotter #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 8,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic     clk,
  input  logic     reset,
  boid_pos_if.slave pos,
  fb_wr_if.master   fb,
  output logic     done
);
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  state_t             state, state_n;
  logic [15:0]        e_col, e_row, d_col, d_row;
  logic               e_neg, d_neg;
  logic [ADDR_W-1:0]  e_addr, d_addr, cur_addr;
  logic [COLOR_W-1:0] color;
  logic               dx, dy, last_sub, cur_clip, step;

  // 640 = 512 + 128, so the row pitch multiply folds into two shifts and an add
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [15:0] col, input logic [15:0] row);
    logic [31:0] r, a;
    r = {16'b0, row};
    if (H_RES == 640) a = (r << 9) + (r << 7) + {16'b0, col};
    else              a = r * 32'(H_RES) + {16'b0, col};
    return ADDR_W'(a);
  endfunction

  function automatic logic off_screen(input logic [15:0] col, input logic [15:0] row,
                                      input logic neg, input logic ox, input logic oy);
    logic [16:0] c, r;
    c = {1'b0, col} + {16'b0, ox};
    r = {1'b0, row} + {16'b0, oy};
    return neg || ({15'b0, c} >= 32'(H_RES)) || ({15'b0, r} >= 32'(V_RES));
  endfunction

  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else       state <= state_n;

  // Base coordinates and addresses are latched so upstream is free once the handshake completes
  always_ff @(posedge clk)
    if (state == IDLE && pos.pos_valid) begin
      e_col  <= pos.px[31:16];
      e_row  <= pos.py[31:16];
      e_neg  <= pos.px[31] | pos.py[31];
      e_addr <= pix_addr(pos.px[31:16], pos.py[31:16]);
      d_col  <= pos.x[31:16];
      d_row  <= pos.y[31:16];
      d_neg  <= pos.x[31] | pos.y[31];
      d_addr <= pix_addr(pos.x[31:16], pos.y[31:16]);
      color  <= pos.boid_color;
    end

`ifdef BOID_SPRITE_2X2_EN
  // Sub-pixel walk: (c,r), (c+1,r), (c,r+1), (c+1,r+1); wraps to 0 between phases
  logic [1:0] sub;
  always_ff @(posedge clk)
    if (reset || state == IDLE)                     sub <= '0;
    else if ((state == ERASE || state == DRAW) && step) sub <= sub + 2'd1;
  assign dx       = sub[0];
  assign dy       = sub[1];
  assign last_sub = &sub;
`else
  assign dx       = 1'b0;
  assign dy       = 1'b0;
  assign last_sub = 1'b1;
`endif

  always_comb begin
    if (state == DRAW) begin
      cur_clip = off_screen(d_col, d_row, d_neg, dx, dy);
      cur_addr = d_addr;
    end else begin
      cur_clip = off_screen(e_col, e_row, e_neg, dx, dy);
      cur_addr = e_addr;
    end
    cur_addr = cur_addr + (dy ? ADDR_W'(H_RES) : '0) + ADDR_W'(dx);
    step     = cur_clip | fb.wr_ready;
  end

  always_comb begin
    state_n       = state;
    pos.pos_ready = 1'b0;
    fb.wr_en      = 1'b0;
    fb.wr_addr    = '0;
    fb.wr_data    = '0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        pos.pos_ready = 1'b1;
        if (pos.pos_valid) state_n = ERASE;
      end
      ERASE: begin
        if (!cur_clip) begin
          fb.wr_en   = 1'b1;
          fb.wr_addr = cur_addr;
          fb.wr_data = BG_COLOR;
        end
        if (step && last_sub) state_n = DRAW;
      end
      DRAW: begin
        if (!cur_clip) begin
          fb.wr_en   = 1'b1;
          fb.wr_addr = cur_addr;
          fb.wr_data = color;
        end
        if (step && last_sub) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_boid_plotter.sv
// Bench for boid_plotter: table of updates with a write scoreboard, plus latency/backpressure/reset sequences.
module tb_boid_plotter;
  localparam int H = 640, V = 480;
`ifdef BOID_SPRITE_2X2_EN
  localparam int NSUB = 4;
`else
  localparam int NSUB = 1;
`endif

  typedef struct { logic [18:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [31:0] x, y, px, py; logic [7:0] c; int n1, n4; } vec_t;

  logic clk, reset, done;
  boid_pos_if #(.COLOR_W(8))            pif();
  fb_wr_if    #(.ADDR_W(19), .COLOR_W(8)) fif();

  boid_plotter dut (.clk(clk), .reset(reset), .pos(pif.slave), .fb(fif.master), .done(done));

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial begin #500000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  wr_t sbq[$];
  int cmp = 0, err = 0, wr_cnt = 0, done_cnt = 0, exp_done = 0;
  logic [18:0] last_addr;
  logic [7:0]  last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference pixel model: floor to integer, clip negatives and off-screen, row-major address
  task automatic push_exp(input logic [31:0] x, y, px, py, input logic [7:0] c);
    logic [31:0] vx, vy;
    int col, row;
    wr_t w;
    for (int ph = 0; ph < 2; ph++) begin
      vx = ph ? x : px;
      vy = ph ? y : py;
      for (int s = 0; s < NSUB; s++) begin
        col = int'(vx[31:16]) + (s & 1);
        row = int'(vy[31:16]) + (s >> 1);
        if (!vx[31] && !vy[31] && col < H && row < V) begin
          w.addr = 19'(row * H + col);
          w.data = ph ? c : 8'h00;
          sbq.push_back(w);
        end
      end
    end
  endtask

  task automatic send(input logic [31:0] x, y, px, py, input logic [7:0] c, input bit push);
    int n;
    @(negedge clk);
    pif.pos_valid = 1; pif.x = x; pif.y = y; pif.px = px; pif.py = py; pif.boid_color = c;
    if (push) begin push_exp(x, y, px, py, c); exp_done++; end
    n = 0;
    while (!pif.pos_ready && n < 200) begin @(negedge clk); n++; end
    if (!pif.pos_ready) begin cmp++; err++; $display("FAIL send_timeout: pos_ready never rose"); end
    @(posedge clk); #1;
    pif.pos_valid = 0;
    pif.x = $urandom; pif.y = $urandom; pif.px = $urandom; pif.py = $urandom; pif.boid_color = 8'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 100);
    if (!done) begin cmp++; err++; $display("FAIL done_timeout: no done pulse within 100 cycles"); end
  endtask

  always @(negedge clk) begin
    wr_t e;
    #1;
    if (!reset && fif.wr_en && fif.wr_ready) begin
      wr_cnt++;
      last_addr = fif.wr_addr;
      last_data = fif.wr_data;
      if (sbq.size() == 0) begin
        cmp++; err++;
        $display("FAIL unexpected_write: addr=%0d data=%0h, none expected", fif.wr_addr, fif.wr_data);
      end else begin
        e = sbq.pop_front();
        chk("sb_wr_addr", 32'(fif.wr_addr), 32'(e.addr));
        chk("sb_wr_data", 32'(fif.wr_data), 32'(e.data));
      end
    end
    if (!reset && done) done_cnt++;
  end

  vec_t tbl[9];

  initial begin
    int w0, dcnt;
    tbl[0] = '{100<<16, 50<<16, 96<<16, 46<<16, 8'hFF, 2, 8};
    tbl[1] = '{640<<16, 10<<16, 5<<16, 5<<16, 8'h11, 1, 4};
    tbl[2] = '{7<<16, 8<<16, 32'hFFFF0000, 3<<16, 8'h22, 1, 4};
    tbl[3] = '{639<<16, 479<<16, 0, 0, 8'h33, 2, 5};
    tbl[4] = '{0, 480<<16, 639<<16, 0, 8'h44, 1, 2};
    tbl[5] = '{20<<16, 30<<16, 20<<16, 30<<16, 8'h5A, 2, 8};
    tbl[6] = '{(10<<16)|32'hFFFF, (2<<16)|32'h8000, (3<<16)|1, (4<<16)|32'hFFFF, 8'h66, 2, 8};
    tbl[7] = '{1<<16, 32'h7FFF0000, 2<<16, 2<<16, 8'h77, 1, 4};
    tbl[8] = '{10<<16, 20<<16, 32'hFFFF0000, 0, 8'h88, 1, 4};

    reset = 1; fif.wr_ready = 1;
    pif.pos_valid = 0; pif.x = 0; pif.y = 0; pif.px = 0; pif.py = 0; pif.boid_color = 0;
    repeat (3) @(negedge clk);
    chk("rst_pos_ready", 32'(pif.pos_ready), 1);
    chk("rst_wr_en",     32'(fif.wr_en), 0);
    chk("rst_wr_addr",   32'(fif.wr_addr), 0);
    chk("rst_wr_data",   32'(fif.wr_data), 0);
    chk("rst_done",      32'(done), 0);
    reset = 0;

    // Cycle-exact latency from the capture edge
    send(100<<16, 50<<16, 96<<16, 46<<16, 8'hFF, 1);
`ifdef BOID_SPRITE_2X2_EN
    for (int i = 0; i < 8; i++) begin @(negedge clk); chk("lat_wr_en", 32'(fif.wr_en), 1); end
    @(negedge clk); chk("lat_done", 32'(done), 1);
    @(negedge clk); chk("lat_ready", 32'(pif.pos_ready), 1);
`else
    @(negedge clk);
    chk("lat_erase_en",   32'(fif.wr_en), 1);
    chk("lat_erase_addr", 32'(fif.wr_addr), 29536);
    chk("lat_erase_data", 32'(fif.wr_data), 0);
    chk("lat_busy_ready", 32'(pif.pos_ready), 0);
    @(negedge clk);
    chk("lat_draw_en",    32'(fif.wr_en), 1);
    chk("lat_draw_addr",  32'(fif.wr_addr), 32100);
    chk("lat_draw_data",  32'(fif.wr_data), 8'hFF);
    chk("lat_draw_done",  32'(done), 0);
    @(negedge clk);
    chk("lat_done",       32'(done), 1);
    chk("lat_done_wr_en", 32'(fif.wr_en), 0);
    @(negedge clk);
    chk("lat_ready",      32'(pif.pos_ready), 1);
    chk("lat_done_pulse", 32'(done), 0);
`endif

    for (int i = 0; i < 9; i++) begin
      w0 = wr_cnt;
      send(tbl[i].x, tbl[i].y, tbl[i].px, tbl[i].py, tbl[i].c, 1);
      wait_done();
      chk($sformatf("vec%0d_nwrites", i), 32'(wr_cnt - w0), 32'((NSUB == 4) ? tbl[i].n4 : tbl[i].n1));
      if (i == 5) chk("same_pixel_final", 32'(last_data), 8'h5A);
    end

    // Backpressure in ERASE with pos_valid wiggling
    fif.wr_ready = 0;
    send(1<<16, 1<<16, 2<<16, 3<<16, 8'h33, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pif.pos_valid = (i != 1); pif.x = 32'(i) << 16; pif.y = 0; pif.px = 0; pif.py = 0;
      chk("bp_wr_en",   32'(fif.wr_en), 1);
      chk("bp_wr_addr", 32'(fif.wr_addr), 1922);
      chk("bp_wr_data", 32'(fif.wr_data), 0);
      chk("bp_ready",   32'(pif.pos_ready), 0);
    end
    @(negedge clk);
    pif.pos_valid = 0;
    fif.wr_ready = 1;
    wait_done();

    // Reset while DRAW is stalled
    fif.wr_ready = 0;
    send(5<<16, 5<<16, 32'hFFFF0000, 0, 8'h77, 0);
    w0 = 0;
    do begin @(negedge clk); w0++; end while (!fif.wr_en && w0 < 10);
    chk("rd_draw_stall_en",   32'(fif.wr_en), 1);
    chk("rd_draw_stall_addr", 32'(fif.wr_addr), 3205);
    reset = 1;
    dcnt = done_cnt;
    @(negedge clk);
    chk("rd_wr_en", 32'(fif.wr_en), 0);
    chk("rd_ready", 32'(pif.pos_ready), 1);
    chk("rd_done",  32'(done), 0);
    reset = 0;
    fif.wr_ready = 1;
    repeat (4) @(negedge clk);
    chk("rd_no_done", 32'(done_cnt), 32'(dcnt));

    send(3<<16, 4<<16, 5<<16, 6<<16, 8'hC3, 1);
    wait_done();
    repeat (2) @(negedge clk);

    chk("sb_empty",   32'(sbq.size()), 0);
    chk("done_count", 32'(done_cnt), 32'(exp_done));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
